mux_scan_sequencer: RTL and testbench

//  Upstream driver of the analog-mux select decoder: generates the 6-bit addr that the decoder turns into
//  the F1/F2/F3 8:1 select lines. Steps addr through a channel window, waits a settle time per channel,

---
 rtl/mux_scan_if.sv | 29 ++
 rtl/mux_scan_sequencer.sv | 107 ++++++++++
 tb/tb_mux_scan_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_if.sv
// mux_scan_if: control, ADC handshake and sample bus of the mux scan sequencer
interface mux_scan_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              start;
  logic              stop;
  logic              continuous;
  logic [ADDR_W-1:0] addr_first;
  logic [ADDR_W-1:0] addr_last;
  logic [ADDR_W-1:0] addr;
  logic              adc_start;
  logic              adc_done;
  logic [DATA_W-1:0] adc_data;
  logic              sample_valid;
  logic [ADDR_W-1:0] sample_addr;
  logic [DATA_W-1:0] sample_data;
  logic              busy;
  logic              scan_done;
  logic              timeout_err;
  modport master (
    input  start, stop, continuous, addr_first, addr_last, adc_done, adc_data,
    output addr, adc_start, sample_valid, sample_addr, sample_data, busy, scan_done, timeout_err
  );
  modport slave (
    output start, stop, continuous, addr_first, addr_last, adc_done, adc_data,
    input  addr, adc_start, sample_valid, sample_addr, sample_data, busy, scan_done, timeout_err
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps the mux address through a channel window, settles, converts and tags samples
module mux_scan_sequencer #(
  parameter int ADDR_W        = 6,
  parameter int DATA_W        = 16,
  parameter int SETTLE_CYCLES = 200,
  parameter int ADC_TIMEOUT   = 1023
) (
  input logic        clk,
  input logic        rst_n,
  mux_scan_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, CONVERT, WAIT_DONE} state_t;
  localparam logic [15:0] SETTLE_L = 16'(SETTLE_CYCLES);
  localparam logic [15:0] TO_L     = 16'(ADC_TIMEOUT);
  state_t            r_state;
  logic [15:0]       r_settle_cnt;
  logic [15:0]       r_to_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_first;
  logic [ADDR_W-1:0] r_last;
  logic              r_cont;
  logic              r_stop_pending;
  logic              r_adc_start;
  logic              r_sample_valid;
  logic [ADDR_W-1:0] r_sample_addr;
  logic [DATA_W-1:0] r_sample_data;
  logic              r_scan_done;
  logic              r_timeout_err;
  logic              w_stop;
  logic              w_last;
  logic              w_wrap;
  logic              w_end;
  // a stop arriving in the advance cycle itself still ends the scan there
  assign w_stop = r_stop_pending | bus.stop;
  assign w_last = r_addr == r_last;
  assign w_wrap = w_last & r_cont & ~w_stop;
  assign w_end  = (w_last | w_stop) & ~w_wrap;
  // window settings are only meaningful once a start is accepted, so they carry no reset
  always_ff @(posedge clk)
    if (r_state == IDLE && bus.start) begin
      r_first <= bus.addr_first;
      r_last  <= bus.addr_last;
      r_cont  <= bus.continuous;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state        <= IDLE;
      r_settle_cnt   <= '0;
      r_to_cnt       <= '0;
      r_addr         <= '0;
      r_stop_pending <= 1'b0;
      r_adc_start    <= 1'b0;
      r_sample_valid <= 1'b0;
      r_sample_addr  <= '0;
      r_sample_data  <= '0;
      r_scan_done    <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_adc_start    <= 1'b0;
      r_sample_valid <= 1'b0;
      r_scan_done    <= 1'b0;
      if (r_state != IDLE) r_stop_pending <= w_stop;
      case (r_state)
        IDLE:
          if (bus.start) begin
            r_addr        <= bus.addr_first;
            r_timeout_err <= 1'b0;
            r_settle_cnt  <= SETTLE_L;
            r_state       <= SETTLE;
          end
        SETTLE:
          if (r_settle_cnt == '0) r_state <= CONVERT;
          else r_settle_cnt <= r_settle_cnt - 16'd1;
        CONVERT: begin
          r_adc_start <= 1'b1;
          r_to_cnt    <= TO_L;
          r_state     <= WAIT_DONE;
        end
        WAIT_DONE:
          if (bus.adc_done || r_to_cnt == '0) begin
            if (bus.adc_done) begin
              r_sample_valid <= 1'b1;
              r_sample_addr  <= r_addr;
              r_sample_data  <= bus.adc_data;
            end else r_timeout_err <= 1'b1;
            if (w_end) begin
              r_scan_done    <= 1'b1;
              r_stop_pending <= 1'b0;
              r_state        <= IDLE;
            end else begin
              r_addr       <= w_wrap ? r_first : r_addr + ADDR_W'(1);
              r_settle_cnt <= SETTLE_L;
              r_state      <= SETTLE;
            end
          end else r_to_cnt <= r_to_cnt - 16'd1;
        default: r_state <= IDLE;
      endcase
    end
  assign bus.addr         = r_addr;
  assign bus.adc_start    = r_adc_start;
  assign bus.sample_valid = r_sample_valid;
  assign bus.sample_addr  = r_sample_addr;
  assign bus.sample_data  = r_sample_data;
  assign bus.busy         = r_state != IDLE;
  assign bus.scan_done    = r_scan_done;
  assign bus.timeout_err  = r_timeout_err;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed and randomized scans checked against a channel-list model
module tb_mux_scan_sequencer;
  localparam int AW = 6;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mux_scan_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mux_scan_sequencer #(.ADDR_W(AW), .DATA_W(DW), .SETTLE_CYCLES(4), .ADC_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  int vectors = 0, miscompares = 0, cyc = 0, done_cnt = 0, viol = 0;
  logic [AW-1:0] sa_q[$];
  logic [DW-1:0] sd_q[$];
  int adc_t[$], sv_t[$], exp_a[$];
  int exp_to, sb, db, ab, vb, c0;
  logic mute_en = 1'b0;
  logic [AW-1:0] mute_ch = '0;
  int dly = 0;
  bit pend = 1'b0;
  logic p_sv = 1'b0, p_as = 1'b0, p_sd = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  // ADC: answers 3 cycles after adc_start with the channel number, unless that channel is muted
  always @(posedge clk) begin
    #1;
    bus.adc_done = 1'b0;
    if (bus.adc_start) begin
      pend = 1'b1;
      dly = 3;
    end else if (pend) begin
      dly--;
      if (dly == 0) begin
        pend = 1'b0;
        bus.adc_done = !(mute_en && bus.addr == mute_ch);
        bus.adc_data = {10'h0, bus.addr};
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.sample_valid) begin
        sa_q.push_back(bus.sample_addr);
        sd_q.push_back(bus.sample_data);
        sv_t.push_back(cyc);
      end
      if (bus.adc_start) adc_t.push_back(cyc);
      if (bus.scan_done) done_cnt++;
      if ((p_sv && bus.sample_valid) || (p_as && bus.adc_start) || (p_sd && bus.scan_done)) viol++;
    end
    p_sv = bus.sample_valid;
    p_as = bus.adc_start;
    p_sd = bus.scan_done;
  end
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic begin_scan;
    sb = sa_q.size();
    db = done_cnt;
    ab = adc_t.size();
    vb = sv_t.size();
  endtask
  task automatic do_start(int f, int l, bit c, bit s);
    tick;
    bus.addr_first = AW'(f);
    bus.addr_last = AW'(l);
    bus.continuous = c;
    bus.start = 1'b1;
    bus.stop = s;
    tick;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    c0 = cyc;
  endtask
  task automatic pulse_stop;
    tick;
    bus.stop = 1'b1;
    tick;
    bus.stop = 1'b0;
  endtask
  task automatic wait_samples(string tag, int n);
    for (int i = 0; i < 3000 && sa_q.size() < sb + n; i++) @(negedge clk);
    chk({tag, "_samples_seen"}, 32'(sa_q.size() >= sb + n), 1);
  endtask
  task automatic wait_done(string tag);
    for (int i = 0; i < 3000 && done_cnt == db; i++) @(negedge clk);
    chk({tag, "_done_seen"}, 32'(done_cnt != db), 1);
    repeat (3) @(negedge clk);
  endtask
  // expected channel list of a one-shot scan: walk first..last modulo 64, drop the muted channel
  task automatic build_exp(int f, int l);
    exp_a.delete();
    exp_to = 0;
    for (int i = 0; i < 64; i++) begin
      int c = (f + i) % 64;
      if (mute_en && c == int'(mute_ch)) exp_to = 1;
      else exp_a.push_back(c);
      if (c == l) break;
    end
  endtask
  task automatic build_cont(int f, int l, int n);
    int span = (l - f + 64) % 64 + 1;
    exp_a.delete();
    exp_to = 0;
    for (int i = 0; i < n; i++) exp_a.push_back((f + i % span) % 64);
  endtask
  task automatic check_scan(string tag, int last_addr);
    chk({tag, "_count"}, 32'(sa_q.size() - sb), 32'(exp_a.size()));
    foreach (exp_a[i])
      if (sb + i < sa_q.size()) begin
        chk({tag, "_sample_addr"}, 32'(sa_q[sb+i]), 32'(exp_a[i]));
        chk({tag, "_sample_data"}, 32'(sd_q[sb+i]), 32'(exp_a[i]));
      end
    chk({tag, "_done_pulses"}, 32'(done_cnt - db), 1);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_addr_hold"}, 32'(bus.addr), 32'(last_addr));
    chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'(exp_to));
  endtask
  task automatic check_zero(string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_addr"}, 32'(bus.addr), 0);
    chk({tag, "_adc_start"}, 32'(bus.adc_start), 0);
    chk({tag, "_sample_valid"}, 32'(bus.sample_valid), 0);
    chk({tag, "_sample_addr"}, 32'(bus.sample_addr), 0);
    chk({tag, "_sample_data"}, 32'(bus.sample_data), 0);
    chk({tag, "_scan_done"}, 32'(bus.scan_done), 0);
    chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 0);
  endtask
  task automatic one_shot(string tag, int f, int l, bit s, bit spurious);
    begin_scan;
    do_start(f, l, 1'b0, s);
    if (spurious) begin
      repeat (3) tick;
      bus.addr_first = AW'(f + 17);
      bus.addr_last = AW'(f + 20);
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
    end
    wait_done(tag);
    build_exp(f, l);
    check_scan(tag, l);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.continuous = 1'b0;
    bus.addr_first = '0;
    bus.addr_last = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    // basic window with latency checks
    begin_scan;
    do_start(3, 5, 1'b0, 1'b0);
    chk("basic_addr_cycle0", 32'(bus.addr), 3);
    chk("basic_busy_cycle0", 32'(bus.busy), 1);
    wait_done("basic");
    build_exp(3, 5);
    check_scan("basic", 5);
    if (adc_t.size() > ab) chk("adc_start_latency", 32'(adc_t[ab] - c0), 6);
    if (sv_t.size() > vb && adc_t.size() > ab) chk("sample_latency", 32'(sv_t[vb] - adc_t[ab]), 4);
    one_shot("wrap", 62, 1, 1'b0, 1'b0);
    // stop while idle must not leak into the next scan
    pulse_stop;
    one_shot("stop_idle", 10, 11, 1'b0, 1'b0);
    one_shot("start_stop_same", 20, 22, 1'b1, 1'b0);
    one_shot("single", 33, 33, 1'b0, 1'b0);
    // continuous single channel, stop during the third settle
    begin_scan;
    do_start(7, 7, 1'b1, 1'b0);
    wait_samples("cont1", 2);
    pulse_stop;
    wait_done("cont1");
    build_cont(7, 7, 3);
    check_scan("cont1", 7);
    repeat (30) @(negedge clk);
    chk("cont1_no_more", 32'(sa_q.size() - sb), 3);
    // continuous window wraps back to the latched first channel
    begin_scan;
    do_start(40, 42, 1'b1, 1'b0);
    wait_samples("cont3", 4);
    pulse_stop;
    wait_done("cont3");
    build_cont(40, 42, 5);
    check_scan("cont3", 41);
    // muted channel times out and is skipped; next start clears the flag
    mute_en = 1'b1;
    mute_ch = 6'd4;
    one_shot("timeout", 3, 5, 1'b0, 1'b0);
    mute_en = 1'b0;
    begin_scan;
    do_start(8, 8, 1'b0, 1'b0);
    chk("timeout_cleared", 32'(bus.timeout_err), 0);
    wait_done("after_to");
    build_exp(8, 8);
    check_scan("after_to", 8);
    // reset in WAIT_DONE; the late adc_done must not produce a sample
    begin_scan;
    do_start(10, 12, 1'b0, 1'b0);
    for (int i = 0; i < 100 && adc_t.size() == ab; i++) @(negedge clk);
    chk("rst_adc_seen", 32'(adc_t.size() > ab), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    tick;
    rst_n = 1'b1;
    begin_scan;
    repeat (12) @(negedge clk);
    chk("rst_no_sample", 32'(sa_q.size() - sb), 0);
    chk("rst_no_done", 32'(done_cnt - db), 0);
    chk("rst_idle", 32'(bus.busy), 0);
    one_shot("post_rst", 10, 12, 1'b0, 1'b0);
    // randomized windows, optional muted channel and ignored mid-scan start
    for (int n = 0; n < 8; n++) begin
      int f = $urandom_range(0, 63);
      int span = $urandom_range(0, 4);
      mute_en = 1'($urandom_range(0, 1));
      mute_ch = AW'(f + $urandom_range(0, span));
      one_shot("rand", f, (f + span) % 64, 1'b0, 1'($urandom_range(0, 1)));
    end
    mute_en = 1'b0;
    chk("pulse_width", 32'(viol), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
